// File: rtl/bft_pkg.sv
// bft_pkg: BFT packet field layout, control port id and packet builder
package bft_pkg;
    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 3;
    localparam int NUM_PORT_BITS = 4;
    localparam int VALID_BIT     = 48;
    localparam int DST_LEAF_LSB  = 45;
    localparam int DST_PORT_LSB  = 41;
    localparam int SRC_LEAF_LSB  = 38;
    localparam int SRC_PORT_LSB  = 34;
    localparam int PAYLOAD_LSB   = 0;
    localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

    function automatic logic [PACKET_BITS-1:0] build_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_LEAF_BITS-1:0] sleaf,
        input logic [NUM_PORT_BITS-1:0] sport,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        logic [PACKET_BITS-1:0] p;
        p = '0;
        p[VALID_BIT] = 1'b1;
        p[DST_LEAF_LSB +: NUM_LEAF_BITS] = leaf;
        p[DST_PORT_LSB +: NUM_PORT_BITS] = port;
        p[SRC_LEAF_LSB +: NUM_LEAF_BITS] = sleaf;
        p[SRC_PORT_LSB +: NUM_PORT_BITS] = sport;
        p[PAYLOAD_LSB +: PAYLOAD_BITS]   = payload;
        return p;
    endfunction
endpackage

// File: rtl/bft_rx_fifo.sv
// bft_rx_fifo: synchronous FIFO with wrap-bit pointers for full/empty detection
module bft_rx_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int PW    = ADDR_BITS + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // status from pointer compare; pushes at full and pops at empty are ignored
    always_comb begin
        full_o  = (wr_q[ADDR_BITS] != rd_q[ADDR_BITS]) && (wr_q[ADDR_BITS-1:0] == rd_q[ADDR_BITS-1:0]);
        empty_o = wr_q == rd_q;
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        dout_o  = mem_q[rd_q[ADDR_BITS-1:0]];
    end

    // pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // storage needs no reset: empty pointers hide stale contents
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[ADDR_BITS-1:0]] <= din_i;
    end
endmodule

// File: rtl/bft_stream_endpoint.sv
// bft_stream_endpoint: network-side BFT endpoint with credit flow control and resend
module bft_stream_endpoint
    import bft_pkg::*;
#(
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter int RX_FIFO_ADDR_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PACKET_BITS-1:0]      din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]      dout_leaf_interface2bft,
    input  logic                        resend,
    output logic                        resend_req,
    input  logic [NUM_LEAF_BITS-1:0]    dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]    dst_port,
    input  logic [NUM_LEAF_BITS-1:0]    src_leaf,
    input  logic [NUM_PORT_BITS-1:0]    src_port,
    input  logic [PAYLOAD_BITS-1:0]     din_user,
    input  logic                        din_vld,
    output logic                        din_ack,
    output logic [PAYLOAD_BITS-1:0]     dout_user,
    output logic                        dout_vld,
    input  logic                        dout_ack,
    output logic [NUM_BRAM_ADDR_BITS:0] credits
);
    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam int SW = (CW > 8 ? CW : 8) + 1;
    localparam logic [SW-1:0] MAX_CREDITS = SW'(2 ** NUM_BRAM_ADDR_BITS);

    logic [PACKET_BITS-1:0] dout_q, dout_d, last_q, last_d, tx_pkt;
    logic [CW-1:0]          credits_q, credits_d;
    logic [SW-1:0]          sum;
    logic                   resend_req_q, resend_req_d;
    logic                   in_vld, in_ctrl, is_upd, is_data;
    logic                   fifo_full, fifo_empty, push, pop;
    logic                   unused_hdr;

    assign unused_hdr = ^{din_leaf_bft2interface[47:45], din_leaf_bft2interface[40:32]};

    // classify incoming packet, gate TX on credits/resend, update credits with saturation
    always_comb begin
        in_vld       = din_leaf_bft2interface[VALID_BIT];
        in_ctrl      = din_leaf_bft2interface[DST_PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT;
        is_upd       = in_vld & in_ctrl;
        is_data      = in_vld & ~in_ctrl;
        din_ack      = din_vld & (credits_q != '0) & ~resend;
        tx_pkt       = build_pkt(dst_leaf, dst_port, src_leaf, src_port, din_user);
        dout_d       = resend ? last_q : (din_ack ? tx_pkt : '0);
        last_d       = din_ack ? tx_pkt : last_q;
        sum          = SW'(credits_q) - SW'(din_ack) + (is_upd ? SW'(din_leaf_bft2interface[PAYLOAD_LSB +: 8]) : '0);
        credits_d    = sum > MAX_CREDITS ? MAX_CREDITS[CW-1:0] : sum[CW-1:0];
        push         = is_data & ~fifo_full;
        resend_req_d = is_data & fifo_full;
        pop          = dout_vld & dout_ack;
    end

    // TX output, replay copy, credit counter and drop notification
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q       <= '0;
            last_q       <= '0;
            credits_q    <= MAX_CREDITS[CW-1:0];
            resend_req_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            last_q       <= last_d;
            credits_q    <= credits_d;
            resend_req_q <= resend_req_d;
        end
    end

    bft_rx_fifo #(
        .WIDTH    (PAYLOAD_BITS),
        .ADDR_BITS(RX_FIFO_ADDR_BITS)
    ) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .din_i  (din_leaf_bft2interface[PAYLOAD_LSB +: PAYLOAD_BITS]),
        .pop_i  (pop),
        .dout_o (dout_user),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign dout_vld                = ~fifo_empty;
    assign dout_leaf_interface2bft = dout_q;
    assign resend_req              = resend_req_q;
    assign credits                 = credits_q;
endmodule

// File: tb/tb_bft_stream_endpoint.sv
// tb_bft_stream_endpoint: vector table, directed corner sequences and random run against a reference model
module tb_bft_stream_endpoint;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [48:0] din_pkt = '0;
    logic [48:0] dout;
    logic        resend = 1'b0;
    logic        resend_req;
    logic [2:0]  dst_leaf = 3'd5;
    logic [3:0]  dst_port = 4'd2;
    logic [2:0]  src_leaf = 3'd1;
    logic [3:0]  src_port = 4'd3;
    logic [31:0] din_user = '0;
    logic        din_vld = 1'b0;
    logic        din_ack;
    logic [31:0] dout_user;
    logic        dout_vld;
    logic        dout_ack = 1'b0;
    logic [7:0]  credits;

    int checks = 0;
    int passes = 0;

    int          m_cred;
    logic [48:0] m_last;
    logic [48:0] m_dout;
    logic        m_rreq;
    logic [31:0] m_q[$];

    logic        a;
    int          n;

    typedef struct {
        logic        vld;
        logic [31:0] user;
        logic        rs;
        logic [48:0] pin;
        logic        dack;
        logic        ack;
        logic [48:0] dout;
        logic [7:0]  cred;
        logic        dvld;
        logic [31:0] duser;
        logic        rreq;
    } vec_t;
    vec_t vecs[6];

    bft_stream_endpoint dut (
        .clk                    (clk),
        .reset                  (reset),
        .din_leaf_bft2interface (din_pkt),
        .dout_leaf_interface2bft(dout),
        .resend                 (resend),
        .resend_req             (resend_req),
        .dst_leaf               (dst_leaf),
        .dst_port               (dst_port),
        .src_leaf               (src_leaf),
        .src_port               (src_port),
        .din_user               (din_user),
        .din_vld                (din_vld),
        .din_ack                (din_ack),
        .dout_user              (dout_user),
        .dout_vld               (dout_vld),
        .dout_ack               (dout_ack),
        .credits                (credits)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] mk(input logic [31:0] pl);
        mk = {1'b1, dst_leaf, dst_port, src_leaf, src_port, 2'b00, pl};
    endfunction

    function automatic logic [48:0] pk(input logic [3:0] port, input logic [31:0] pl);
        pk = {1'b1, 3'd5, port, 3'd6, 4'd7, 2'b00, pl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cred = 128;
        m_last = '0;
        m_dout = '0;
        m_rreq = 1'b0;
        m_q.delete();
    endtask

    task automatic idle_inputs();
        din_vld = 1'b0; din_user = '0; resend = 1'b0; din_pkt = '0; dout_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic vld, input logic [31:0] user, input logic rs,
                        input logic [48:0] pin, input logic dack, output logic acc);
        logic upd, dat, full, pop;
        @(negedge clk);
        din_vld = vld; din_user = user; resend = rs; din_pkt = pin; dout_ack = dack;
        #1;
        acc = vld && (m_cred != 0) && !rs;
        chk("din_ack", din_ack, acc);
        upd  = pin[48] && (pin[44:41] == 4'd0);
        dat  = pin[48] && (pin[44:41] != 4'd0);
        full = m_q.size() == 4;
        pop  = (m_q.size() != 0) && dack;
        m_dout = rs ? m_last : (acc ? mk(user) : '0);
        if (acc) m_last = mk(user);
        m_cred = m_cred - int'(acc) + (upd ? int'(pin[7:0]) : 0);
        if (m_cred > 128) m_cred = 128;
        m_rreq = dat && full;
        if (pop) void'(m_q.pop_front());
        if (dat && !full) m_q.push_back(pin[31:0]);
        @(posedge clk);
        #1;
        chk("dout", dout, m_dout);
        chk("credits", credits, 64'(m_cred));
        chk("dout_vld", dout_vld, m_q.size() != 0);
        if (m_q.size() != 0) chk("dout_user", dout_user, m_q[0]);
        chk("resend_req", resend_req, m_rreq);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 49'd0,          1'b0, 1'b1, 49'h1_A44C_DEADBEEF, 8'd127, 1'b0, 32'd0,     1'b0};
        vecs[1] = '{1'b0, 32'd0,        1'b0, 49'd0,          1'b0, 1'b0, 49'd0,               8'd127, 1'b0, 32'd0,     1'b0};
        vecs[2] = '{1'b0, 32'd0,        1'b0, pk(4'd1, 32'hA5), 1'b0, 1'b0, 49'd0,             8'd127, 1'b1, 32'hA5,    1'b0};
        vecs[3] = '{1'b1, 32'h22,       1'b0, pk(4'd0, 32'd1),  1'b0, 1'b1, mk(32'h22),        8'd127, 1'b1, 32'hA5,    1'b0};
        vecs[4] = '{1'b1, 32'h44,       1'b1, 49'd0,          1'b1, 1'b0, mk(32'h22),          8'd127, 1'b0, 32'd0,     1'b0};
        vecs[5] = '{1'b1, 32'h33,       1'b0, pk(4'd0, 32'd200), 1'b0, 1'b1, mk(32'h33),       8'd128, 1'b0, 32'd0,     1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_dout", dout, 49'd0);
        chk("reset_credits", credits, 8'd128);
        chk("reset_dout_vld", dout_vld, 1'b0);
        chk("reset_resend_req", resend_req, 1'b0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din_vld = vecs[i].vld; din_user = vecs[i].user; resend = vecs[i].rs;
            din_pkt = vecs[i].pin; dout_ack = vecs[i].dack;
            #1;
            chk($sformatf("vec%0d_ack", i), din_ack, vecs[i].ack);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("vec%0d_credits", i), credits, vecs[i].cred);
            chk($sformatf("vec%0d_dout_vld", i), dout_vld, vecs[i].dvld);
            if (vecs[i].dvld) chk($sformatf("vec%0d_dout_user", i), dout_user, vecs[i].duser);
            chk($sformatf("vec%0d_resend_req", i), resend_req, vecs[i].rreq);
        end

        do_reset();
        n = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 32'(i), 1'b0, '0, 1'b0, a);
            n += int'(a);
        end
        chk("stream_accepts", 64'(n), 64'd128);
        chk("stream_credits_zero", credits, 8'd0);
        step(1'b1, 32'h55, 1'b0, '0, 1'b0, a);
        chk("stream_blocked", a, 1'b0);
        step(1'b1, 32'h56, 1'b0, pk(4'd0, 32'd64), 1'b0, a);
        chk("stream_blocked_during_update", a, 1'b0);
        chk("stream_update64", credits, 8'd64);
        step(1'b1, 32'h57, 1'b0, '0, 1'b0, a);
        chk("stream_resumes", a, 1'b1);

        do_reset();
        n = 0;
        step(1'b1, 32'h11, 1'b0, '0, 1'b0, a);
        n += int'(dout == mk(32'h11));
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h99, 1'b1, '0, 1'b0, a);
            chk("resend_ack_low", a, 1'b0);
            n += int'(dout == mk(32'h11));
        end
        chk("resend_copies", 64'(n), 64'd3);
        chk("resend_credits", credits, 8'd127);

        do_reset();
        step(1'b1, 32'h1, 1'b0, '0, 1'b0, a);
        step(1'b1, 32'h2, 1'b0, pk(4'd0, 32'd5), 1'b0, a);
        chk("sat_send_plus_update", credits, 8'd128);
        for (int i = 0; i < 118; i++) step(1'b1, 32'(i), 1'b0, '0, 1'b0, a);
        chk("sat_at_ten", credits, 8'd10);
        step(1'b0, '0, 1'b0, pk(4'd0, 32'd200), 1'b0, a);
        chk("sat_update200", credits, 8'd128);

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, '0, 1'b0, pk(4'd1, 32'(i)), 1'b0, a);
            chk($sformatf("fifo_rreq_push%0d", i), resend_req, i == 5);
        end
        for (int i = 1; i <= 4; i++) begin
            chk("fifo_pop_order", dout_user, 32'(i));
            step(1'b0, '0, 1'b0, '0, 1'b1, a);
        end
        chk("fifo_drained", dout_vld, 1'b0);

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 1'b0, pk(4'd9, 32'h100 + 32'(i)), 1'b0, a);
        for (int i = 0; i < 75; i++) step(1'b1, 32'(i), 1'b0, '0, 1'b0, a);
        chk("midrst_pre_credits", credits, 8'd50);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_dout_vld", dout_vld, 1'b0);
        chk("midrst_credits", credits, 8'd128);
        chk("midrst_dout", dout, 49'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            logic [48:0] pin;
            int r;
            r = int'($urandom_range(0, 15));
            pin = (r <= 2) ? pk(4'($urandom_range(1, 15)), $urandom()) :
                  (r == 3) ? pk(4'd0, 32'($urandom_range(0, 8))) :
                  (r == 4) ? {1'b0, 16'($urandom()), 32'($urandom())} : 49'd0;
            step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 7) == 0, pin,
                 $urandom_range(0, 2) == 0, a);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bft_stream_endpoint.md
Name: bft_stream_endpoint

Overview:
- Network-side counterpart of a leaf interface: the far end of a leaf's BFT packet link.
- Packetizes a 32-bit vld/ack user stream into 49-bit BFT packets addressed to one configured leaf and port.
- Enforces credit flow control using the leaf's freespace-update packets.
- Unpacks incoming data packets into a vld/ack output stream through a small FIFO.
- Handles the resend handshake in both directions.
- Used by host/test harnesses and page-to-page links that drive leaf interfaces.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, data payload width.
- NUM_LEAF_BITS, 3, leaf address width.
- NUM_PORT_BITS, 4, port field width.
- NUM_BRAM_ADDR_BITS, 7, log2 of the receiving leaf's buffer depth; initial credits = 2^NUM_BRAM_ADDR_BITS.
- RX_FIFO_ADDR_BITS, 2, log2 of the RX FIFO depth (default 4 entries).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- din_leaf_bft2interface  in  49  packets from the network.
- dout_leaf_interface2bft  out  49  packets to the network; registered.
- resend  in  1  network request to reissue the last emitted packet.
- resend_req  out  1  request to the network to resend a dropped incoming packet.
- dst_leaf  in  3  destination leaf; static during operation.
- dst_port  in  4  destination port; static, must be nonzero.
- src_leaf  in  3  own leaf address, inserted into packets.
- src_port  in  4  own port, inserted into packets.
- din_user  in  32  TX payload.
- din_vld  in  1  TX payload valid.
- din_ack  out  1  TX accept; combinational.
- dout_user  out  32  RX payload.
- dout_vld  out  1  RX valid.
- dout_ack  in  1  RX accept.
- credits  out  8  current credit count (width NUM_BRAM_ADDR_BITS+1).

Behaviour:
- Packet format:
  - [48] valid
  - [47:45] dest leaf
  - [44:41] dest port
  - [40:38] src leaf
  - [37:34] src port
  - [33:32] reserved, driven 0
  - [31:0] payload
- Port 0 is the control port.
- Reset values (asynchronous assert, synchronous release):
  - dout_leaf_interface2bft = 0, last_pkt = 0.
  - credits = 128.
  - RX FIFO empty, so dout_vld = 0.
  - resend_req = 0.
- TX accept: din_ack = din_vld & (credits != 0) & ~resend.
- TX send: on accept, the next cycle's dout = {1, dst_leaf, dst_port, src_leaf, src_port, 2'b00, din_user}.
  - The same value is stored into last_pkt and credits decrement by 1.
  - Latency is 1 cycle.
- TX idle: with no accept and no resend, the next cycle's dout = 0 (valid bit low).
- resend=1 in cycle N:
  - The cycle N+1 dout equals last_pkt.
  - No input is accepted in cycle N and credits are unchanged.
  - Consecutive resend cycles reissue last_pkt every cycle.
  - Resend before any send reissues 0, which is harmless.
- Credit update:
  - Trigger: an incoming packet with [48]=1 and port field [44:41]=0 is a freespace update.
  - Effect: credits += payload[7:0].
  - Saturation: the result saturates at 128.
  - Same cycle as a send: result = sat(credits - 1 + update), computed in a 9-bit intermediate.
  - Update packets never enter the RX FIFO.
- RX data:
  - An incoming packet with [48]=1 and a nonzero port is data.
  - If the FIFO is not full, payload [31:0] is pushed.
  - If the FIFO is full, the packet is discarded and resend_req=1 for exactly the next cycle.
  - Fullness is evaluated before the same-cycle pop, so a push at full is rejected even when dout_ack pops.
- RX output:
  - dout_vld = ~empty; dout_user = FIFO head.
  - Pop when dout_vld & dout_ack.
  - Data appears on dout_vld the cycle after the push (1-cycle latency).
- Pointers: FIFO pointers carry one extra wrap bit; full/empty are derived from pointer compare; wrap-around is modulo depth.
- Reset mid-operation: all state returns to reset values immediately; in-flight packets and FIFO contents are lost.

Decomposition:
- Shared package bft_pkg holds:
  - field offset/width constants: valid bit, leaf/port/src field LSBs, payload LSB;
  - CTRL_PORT = 0;
  - a packet-build function taking leaf/port/src/payload.
- One natural sub-module: bft_rx_fifo, a synchronous FIFO parameterized by width and address bits, with push/pop/full/empty.
- Credit logic and TX register stay in the top level.

Test Plan:
- Reset, then din_vld=1 with din_user=0xDEADBEEF, dst_leaf=5, dst_port=2, src_leaf=1, src_port=3 -> next cycle dout = {1,101,0010,001,0011,00,DEADBEEF}; credits 128→127.
- Stream 128 words with no updates -> all 128 accepted; credits = 0; din_ack = 0 thereafter. Inject update packet (port 0, payload 64) -> credits = 64; sending resumes the following cycle.
- Send 0x11, then assert resend for 2 cycles while din_vld=1 -> dout shows the 0x11 packet 3 times in total; din_ack low during resend; credits decrement only once.
- At credits=127, send plus update(5) in the same cycle -> credits = 128 (saturated); update(200) at credits=10 -> 128.
- Push 5 data packets (port 1) with dout_ack=0 -> 4 buffered, 5th dropped, resend_req pulses 1 cycle. Then dout_ack=1 -> payloads pop in order 1..4.
- Assert reset while the FIFO holds 3 entries and credits = 50 -> dout_vld = 0, credits = 128, dout = 0 immediately.
